banked_regfile: RTL and testbench

BANKED_REGFILE -- requirements
Module: banked_regfile

---
 rtl/banked_regfile.sv | 75 +++++++
 tb/tb_banked_regfile.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/banked_regfile.sv
// banked_regfile: register file with hardwired r0, optional write forwarding and a sequential clear engine
module banked_regfile #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 32,
    parameter int NUM_WATCH = 5,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                        clock,
    input  logic                        ctrl_reset,
    input  logic                        ctrl_writeEnable,
    input  logic [ADDR_W-1:0]           ctrl_writeReg,
    input  logic [DATA_W-1:0]           data_writeReg,
    input  logic [ADDR_W-1:0]           ctrl_readRegA,
    input  logic [ADDR_W-1:0]           ctrl_readRegB,
    input  logic                        ctrl_clear,
    output logic [DATA_W-1:0]           data_readRegA,
    output logic [DATA_W-1:0]           data_readRegB,
    output logic [NUM_WATCH*DATA_W-1:0] watch_data,
    output logic                        clear_busy,
    output logic                        write_drop
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic busy_q, busy_d, drop_q, drop_d;
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [2**ADDR_W-1:0] legal;
    logic wr_legal, wr_ok, last;
    for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_map
        if (k > 0 && k < DEPTH) begin : g_in
            assign mem[k] = regs_q[k];
            assign legal[k] = 1'b1;
        end else begin : g_out
            assign mem[k] = '0;
            assign legal[k] = 1'b0;
        end
    end
    for (genvar k = 1; k <= NUM_WATCH; k++) begin : g_watch
        assign watch_data[(k-1)*DATA_W +: DATA_W] = regs_q[k];
    end
    assign wr_legal = ctrl_writeEnable && legal[ctrl_writeReg];
    assign wr_ok = wr_legal && state_q == IDLE;
    assign last = ptr_q == ADDR_W'(DEPTH-1);
    assign data_readRegA = (BYPASS != 0 && wr_ok && ctrl_readRegA == ctrl_writeReg) ? data_writeReg : mem[ctrl_readRegA];
    assign data_readRegB = (BYPASS != 0 && wr_ok && ctrl_readRegB == ctrl_writeReg) ? data_writeReg : mem[ctrl_readRegB];
    assign clear_busy = busy_q;
    assign write_drop = drop_q;
    always_comb begin
        state_d = state_q == IDLE ? (ctrl_clear ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
        ptr_d = state_q == IDLE ? (ctrl_clear ? ADDR_W'(1) : ptr_q) : (last ? '0 : ptr_q + ADDR_W'(1));
        busy_d = state_d == CLEAR;
        drop_d = wr_legal && state_q == CLEAR;
        for (int i = 1; i < DEPTH; i++)
            regs_d[i] = (wr_ok && ctrl_writeReg == ADDR_W'(i)) ? data_writeReg :
                        (state_q == CLEAR && ptr_q == ADDR_W'(i)) ? '0 : regs_q[i];
    end
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            busy_q <= 1'b0;
            drop_q <= 1'b0;
            for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            busy_q <= busy_d;
            drop_q <= drop_d;
            regs_q <= regs_d;
        end
    end
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: scoreboard bench driving a DEPTH=32/BYPASS=1 and a DEPTH=20/BYPASS=0 instance in parallel
module tb_banked_regfile;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic ctrl_reset, we, clr;
    logic [4:0] waddr, ra, rb;
    logic [31:0] wdata;
    logic [31:0] a_ra, a_rb, b_ra, b_rb;
    logic [159:0] a_w, b_w;
    logic a_busy, a_drop, b_busy, b_drop;
    banked_regfile #(.DATA_W(32), .DEPTH(32), .NUM_WATCH(5), .BYPASS(1)) dut_a (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
        .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .ctrl_clear(clr),
        .data_readRegA(a_ra), .data_readRegB(a_rb), .watch_data(a_w), .clear_busy(a_busy),
        .write_drop(a_drop));
    banked_regfile #(.DATA_W(32), .DEPTH(20), .NUM_WATCH(5), .BYPASS(0)) dut_b (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(we), .ctrl_writeReg(waddr),
        .data_writeReg(wdata), .ctrl_readRegA(ra), .ctrl_readRegB(rb), .ctrl_clear(clr),
        .data_readRegA(b_ra), .data_readRegB(b_rb), .watch_data(b_w), .clear_busy(b_busy),
        .write_drop(b_drop));
    typedef struct {string tag; logic [31:0] exp;} exp_t;
    exp_t sb[$];
    int passed = 0, failed = 0, total = 0;
    task automatic push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask
    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) passed++;
            else begin
                failed++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask
    function automatic logic [31:0] fv(input int i);
        return 32'h1000_0000 | i;
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int na, nb, da, db, da_at;
        logic [31:0] acc;
        ctrl_reset = 0; we = 0; waddr = 0; wdata = 0; ra = 0; rb = 0; clr = 0;
        #3;
        push("rst_busy", 0); chk({31'b0, a_busy});
        push("rst_drop", 0); chk({31'b0, a_drop});
        push("rst_watch", 0); chk({31'b0, |a_w});
        push("rst_readA", 0); chk(a_ra);
        #10 ctrl_reset = 1;
        cyc();
        we = 1; waddr = 3; wdata = 32'hDEAD_BEEF;
        cyc();
        we = 0; ra = 3; rb = 0; #1;
        push("r3_readA", 32'hDEAD_BEEF); chk(a_ra);
        push("r0_readB", 0); chk(a_rb);
        push("watch_slice2", 32'hDEAD_BEEF); chk(a_w[95:64]);
        push("b_r3_readA", 32'hDEAD_BEEF); chk(b_ra);
        we = 1; waddr = 7; wdata = 32'h1234_5678; ra = 7; rb = 7; #1;
        push("bypass_A", 32'h1234_5678); chk(a_ra);
        push("bypass_B", 32'h1234_5678); chk(a_rb);
        push("nobypass_old", 0); chk(b_ra);
        cyc();
        we = 0; #1;
        push("nobypass_after", 32'h1234_5678); chk(b_ra);
        for (int i = 1; i < 32; i++) begin
            we = 1; waddr = i[4:0]; wdata = fv(i);
            cyc();
        end
        we = 0; ra = 1; rb = 19; #1;
        push("fill_r1", fv(1)); chk(a_ra);
        push("b_fill_r19", fv(19)); chk(b_rb);
        push("watch_r5", fv(5)); chk(a_w[159:128]);
        clr = 1; we = 1; waddr = 9; wdata = 32'h0000_CAFE;
        cyc();
        clr = 0; we = 0; ra = 31; rb = 9; #1;
        push("clr_r31_live", fv(31)); chk(a_ra);
        push("clr_pulse_write", 32'h0000_CAFE); chk(a_rb);
        na = 0; nb = 0; da = 0; db = 0; da_at = -1;
        for (int n = 0; n < 40 && (a_busy || b_busy); n++) begin
            if (a_busy) na++;
            if (b_busy) nb++;
            if (a_drop) begin da++; da_at = n; end
            if (b_drop) db++;
            we = (n == 2); waddr = 5; wdata = 32'hA5; clr = (n == 4); ra = (n == 2) ? 5'd5 : 5'd31;
            if (n == 2) begin
                #1;
                push("clear_no_bypass", fv(5)); chk(a_ra);
            end
            cyc();
        end
        we = 0; clr = 0;
        push("busy_len_a", 31); chk(na);
        push("busy_len_b", 19); chk(nb);
        push("drop_count_a", 1); chk(da);
        push("drop_cycle_a", 3); chk(da_at);
        push("drop_count_b", 1); chk(db);
        acc = 0;
        for (int i = 0; i < 32; i++) begin
            ra = i[4:0]; rb = i[4:0]; #1;
            acc |= a_ra | a_rb | b_ra | b_rb;
        end
        push("all_zero_after_clear", 0); chk(acc);
        push("watch_zero_after_clear", 0); chk({31'b0, |a_w});
        cyc();
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF; ra = 0; rb = 0; #1;
        push("r0_no_bypass", 0); chk(a_ra);
        cyc();
        push("r0_no_drop", 0); chk({31'b0, a_drop});
        push("r0_read", 0); chk(a_ra);
        waddr = 25; wdata = 32'h55; ra = 25; rb = 25;
        cyc();
        we = 0; #1;
        push("b_oor_read", 0); chk(b_ra);
        push("b_oor_no_drop", 0); chk({31'b0, b_drop});
        push("a_r25_read", 32'h55); chk(a_ra);
        we = 1; waddr = 31; wdata = 32'h1111;
        cyc();
        we = 0; clr = 1;
        cyc();
        clr = 0;
        repeat (5) cyc();
        ra = 31; #1;
        push("pre_rst_r31", 32'h1111); chk(a_ra);
        push("pre_rst_busy", 1); chk({31'b0, a_busy});
        #2 ctrl_reset = 0;
        #1;
        push("rst_mid_busy", 0); chk({31'b0, a_busy});
        push("rst_mid_r31", 0); chk(a_ra);
        push("rst_mid_drop", 0); chk({31'b0, a_drop});
        push("rst_mid_b_busy", 0); chk({31'b0, b_busy});
        #3 ctrl_reset = 1;
        cyc();
        push("post_rst_busy", 0); chk({31'b0, a_busy});
        we = 1; waddr = 4; wdata = 32'h44;
        cyc();
        we = 0; ra = 4; #1;
        push("resume_r4", 32'h44); chk(a_ra);
        push("resume_watch_r4", 32'h44); chk(a_w[127:96]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
